// File: rtl/fft_out_streamer.sv
// fft_out_streamer
// Shadow-buffers one FFT result frame on the stage's frame_valid pulse and
// streams it out one complex word per cycle over a valid/ready handshake.
// Each word is tagged with its bin index, a last flag and a |re|+|im|
// magnitude estimate. The FFT stage can start its next frame while this one
// drains. A frame arriving while another is still held is dropped and
// recorded in the sticky overrun flag.
module fft_out_streamer #(
  parameter int N      = 32,
  parameter int MSB    = 16,
  parameter int BITREV = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_valid,
  input  logic [N*MSB-1:0]     fft_data_in,
  input  logic                 o_ready,
  input  logic                 clr_overrun,
  output logic                 o_valid,
  output logic [MSB-1:0]       o_data,
  output logic [MSB/2:0]       o_mag,
  output logic [$clog2(N)-1:0] o_index,
  output logic                 o_last,
  output logic                 busy,
  output logic                 overrun
);

  localparam int LW = $clog2(N);
  localparam int HW = MSB / 2;
  localparam logic [LW-1:0] CNT_LAST = LW'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2
  } state_e;

  // Absolute value of a signed half-word, widened by one bit so that the
  // most negative input (-2^(HW-1)) maps to +2^(HW-1) without overflow.
  function automatic logic [HW:0] abs_ext(input logic [HW-1:0] v);
    logic [HW:0] ext;
    ext = {v[HW-1], v};
    if (v[HW-1]) begin
      abs_ext = ~ext + {{HW{1'b0}}, 1'b1};
    end else begin
      abs_ext = ext;
    end
  endfunction

  // |re| + |im| of one complex word. Both terms are at most 2^(HW-1), so
  // the sum is at most 2^HW and always fits in HW+1 bits.
  function automatic logic [HW:0] mag_est(input logic [MSB-1:0] w);
    mag_est = abs_ext(w[MSB-1:HW]) + abs_ext(w[HW-1:0]);
  endfunction

  // Mirror the bit order of a bin counter.
  function automatic logic [LW-1:0] bit_rev(input logic [LW-1:0] c);
    logic [LW-1:0] r;
    r = {LW{1'b0}};
    for (int i = 0; i < LW; i++) begin
      r[i] = c[LW-1-i];
    end
    bit_rev = r;
  endfunction

  // Registered state
  state_e             state_q,   state_d;
  logic [N*MSB-1:0]   shadow_q,  shadow_d;
  logic [LW-1:0]      cnt_q,     cnt_d;
  logic               o_valid_q, o_valid_d;
  logic [MSB-1:0]     o_data_q,  o_data_d;
  logic [HW:0]        o_mag_q,   o_mag_d;
  logic [LW-1:0]      o_index_q, o_index_d;
  logic               o_last_q,  o_last_d;
  logic               busy_q,    busy_d;
  logic               overrun_q, overrun_d;

  // Combinational helpers
  logic [MSB-1:0]     words_s [N];
  logic               xfer_s;
  logic               last_xfer_s;
  logic               drop_s;
  logic [LW-1:0]      pres_cnt_s;
  logic [LW-1:0]      pres_bin_s;
  logic [MSB-1:0]     pres_word_s;
  logic [HW:0]        pres_mag_s;
  logic               pres_last_s;

  // Slice the shadow frame into an indexable array of complex words.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      words_s[k] = shadow_q[k*MSB +: MSB];
    end
  end

  // Handshake decode and selection of the word to present on the next edge.
  // In LOAD the counter already points at word 0; in STREAM the next word is
  // one past the word currently on the outputs.
  always_comb begin
    xfer_s      = o_valid_q & o_ready;
    last_xfer_s = xfer_s & o_last_q;
    if (state_q == ST_LOAD) begin
      pres_cnt_s = cnt_q;
    end else begin
      pres_cnt_s = cnt_q + LW'(1);
    end
    if (BITREV != 0) begin
      pres_bin_s = bit_rev(pres_cnt_s);
    end else begin
      pres_bin_s = pres_cnt_s;
    end
    pres_word_s = words_s[pres_bin_s];
    pres_mag_s  = mag_est(pres_word_s);
    pres_last_s = (pres_cnt_s == CNT_LAST);
  end

  // Next-state, capture and output-register logic of the streaming FSM.
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    cnt_d     = cnt_q;
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_mag_d   = o_mag_q;
    o_index_d = o_index_q;
    o_last_d  = o_last_q;
    case (state_q)
      ST_IDLE: begin
        if (frame_valid) begin
          state_d  = ST_LOAD;
          shadow_d = fft_data_in;
          cnt_d    = {LW{1'b0}};
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // Shadow is now stable: register word 0 onto the outputs.
        state_d   = ST_STREAM;
        cnt_d     = pres_cnt_s;
        o_valid_d = 1'b1;
        o_data_d  = pres_word_s;
        o_mag_d   = pres_mag_s;
        o_index_d = pres_bin_s;
        o_last_d  = pres_last_s;
      end
      ST_STREAM: begin
        if (last_xfer_s) begin
          // Final word accepted; a coincident frame is taken back-to-back.
          o_valid_d = 1'b0;
          o_last_d  = 1'b0;
          if (frame_valid) begin
            state_d  = ST_LOAD;
            shadow_d = fft_data_in;
            cnt_d    = {LW{1'b0}};
          end else begin
            state_d  = ST_IDLE;
          end
        end else if (xfer_s) begin
          state_d   = ST_STREAM;
          cnt_d     = pres_cnt_s;
          o_valid_d = 1'b1;
          o_data_d  = pres_word_s;
          o_mag_d   = pres_mag_s;
          o_index_d = pres_bin_s;
          o_last_d  = pres_last_s;
        end else begin
          // Stalled or idle handshake: every output holds.
          state_d   = ST_STREAM;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cnt_d     = {LW{1'b0}};
        o_valid_d = 1'b0;
        o_last_d  = 1'b0;
      end
    endcase
  end

  // busy tracks the registered state; overrun is sticky with set over clear.
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    if (state_q == ST_LOAD) begin
      drop_s = frame_valid;
    end else if (state_q == ST_STREAM) begin
      drop_s = frame_valid & ~last_xfer_s;
    end else begin
      drop_s = 1'b0;
    end
    if (drop_s) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shadow_q  <= {(N*MSB){1'b0}};
      cnt_q     <= {LW{1'b0}};
      o_valid_q <= 1'b0;
      o_data_q  <= {MSB{1'b0}};
      o_mag_q   <= {(HW+1){1'b0}};
      o_index_q <= {LW{1'b0}};
      o_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      cnt_q     <= cnt_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_mag_q   <= o_mag_d;
      o_index_q <= o_index_d;
      o_last_q  <= o_last_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
  assign o_mag   = o_mag_q;
  assign o_index = o_index_q;
  assign o_last  = o_last_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_fft_out_streamer.sv
// Testbench for fft_out_streamer: a 32-point natural-order instance and an
// 8-point bit-reversed instance, checked against a frame-level model.
module tb_fft_out_streamer;

  localparam int N   = 32;
  localparam int N8  = 8;
  localparam int MSB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic                 frame_valid;
  logic [N*MSB-1:0]     fft_data_in;
  logic                 o_ready;
  logic                 clr_overrun;
  logic                 o_valid;
  logic [MSB-1:0]       o_data;
  logic [MSB/2:0]       o_mag;
  logic [4:0]           o_index;
  logic                 o_last;
  logic                 busy;
  logic                 overrun;

  logic                 fv8;
  logic [N8*MSB-1:0]    din8;
  logic                 rdy8;
  logic                 clr8;
  logic                 o_valid8;
  logic [MSB-1:0]       o_data8;
  logic [MSB/2:0]       o_mag8;
  logic [2:0]           o_index8;
  logic                 o_last8;
  logic                 busy8;
  logic                 overrun8;

  fft_out_streamer #(.N(N), .MSB(MSB), .BITREV(0)) dut (
    .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid), .fft_data_in(fft_data_in),
    .o_ready(o_ready), .clr_overrun(clr_overrun), .o_valid(o_valid), .o_data(o_data),
    .o_mag(o_mag), .o_index(o_index), .o_last(o_last), .busy(busy), .overrun(overrun)
  );

  fft_out_streamer #(.N(N8), .MSB(MSB), .BITREV(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .frame_valid(fv8), .fft_data_in(din8),
    .o_ready(rdy8), .clr_overrun(clr8), .o_valid(o_valid8), .o_data(o_data8),
    .o_mag(o_mag8), .o_index(o_index8), .o_last(o_last8), .busy(busy8), .overrun(overrun8)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_frame [N];
  logic [15:0] nxt_frame [N];
  int          obs_mag   [N];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int ref_mag(input logic [15:0] w);
    int re;
    int im;
    re = int'($signed(w[15:8]));
    im = int'($signed(w[7:0]));
    return sabs(re) + sabs(im);
  endfunction

  function automatic int ref_rev(input int c, input int bits);
    int r;
    int v;
    r = 0;
    v = c;
    for (int i = 0; i < bits; i++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  function automatic logic [N*MSB-1:0] pack_frame(input logic [15:0] f [N]);
    logic [N*MSB-1:0] v;
    for (int k = 0; k < N; k++) v[k*MSB +: MSB] = f[k];
    return v;
  endfunction

  task automatic start_frame32();
    frame_valid = 1'b1;
    fft_data_in = pack_frame(exp_frame);
    step();
    frame_valid = 1'b0;
  endtask

  // Accept the whole frame in exp_frame, comparing every transferred word and
  // the stability of outputs while stalled. mode: 0 ready=1, 1 ready 1,0,0,1,
  // 2 random. A frame is injected while word inject_pos is on the outputs.
  task automatic drain32(input int mode, input int inject_pos,
                         input logic [N*MSB-1:0] inj, output int used);
    int pos;
    int cyc;
    bit stalled;
    bit injected;
    logic rdy;
    logic [15:0] p_data;
    logic [8:0]  p_mag;
    logic [4:0]  p_idx;
    logic        p_last;
    pos = 0; cyc = 0; stalled = 1'b0; injected = 1'b0;
    p_data = 16'd0; p_mag = 9'd0; p_idx = 5'd0; p_last = 1'b0;
    while (pos < N && cyc < 20 * N) begin
      if (stalled) begin
        checks++;
        if (o_valid !== 1'b1 || o_data !== p_data || o_mag !== p_mag ||
            o_index !== p_idx || o_last !== p_last) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b d=%h m=%0d i=%0d l=%0b, want v=1 d=%h m=%0d i=%0d l=%0b",
                   o_valid, o_data, o_mag, o_index, o_last, p_data, p_mag, p_idx, p_last);
        end
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      o_ready     = rdy;
      frame_valid = 1'b0;
      if (o_valid && !injected && pos == inject_pos) begin
        frame_valid = 1'b1;
        fft_data_in = inj;
        injected    = 1'b1;
      end
      if (o_valid && rdy) begin
        checks++;
        if (o_index !== 5'(pos) || o_data !== exp_frame[pos] ||
            o_mag !== 9'(ref_mag(exp_frame[pos])) || o_last !== (pos == N - 1)) begin
          errors++;
          $display("FAIL word[%0d]: got i=%0d d=%h m=%0d l=%0b, want i=%0d d=%h m=%0d l=%0b",
                   pos, o_index, o_data, o_mag, o_last, pos, exp_frame[pos],
                   ref_mag(exp_frame[pos]), (pos == N - 1));
        end
        obs_mag[pos] = int'(o_mag);
        pos++;
      end
      stalled = o_valid && !rdy;
      p_data = o_data; p_mag = o_mag; p_idx = o_index; p_last = o_last;
      step();
      cyc++;
    end
    frame_valid = 1'b0;
    o_ready     = 1'b0;
    used        = cyc;
    checks++;
    if (pos < N) begin
      errors++;
      $display("FAIL drain_timeout: got %0d words, want %0d", pos, N);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (o_valid !== 1'b0 || o_last !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 ||
        o_data !== 16'd0 || o_mag !== 9'd0 || o_index !== 5'd0 || o_valid8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got v=%0b l=%0b b=%0b o=%0b d=%h m=%0d i=%0d v8=%0b, want all 0",
               o_valid, o_last, busy, overrun, o_data, o_mag, o_index, o_valid8);
    end
  endtask

  task automatic test_natural();
    int used;
    for (int k = 0; k < N; k++) exp_frame[k] = {8'(k), 8'(-k)};
    start_frame32();
    checks++;
    if (o_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL latency_load: got v=%0b busy=%0b, want v=0 busy=1", o_valid, busy);
    end
    step();
    checks++;
    if (o_valid !== 1'b1 || o_index !== 5'd0) begin
      errors++;
      $display("FAIL latency_first: got v=%0b i=%0d, want v=1 i=0", o_valid, o_index);
    end
    drain32(0, -1, {(N*MSB){1'b0}}, used);
    checks++;
    if (used !== N) begin
      errors++;
      $display("FAIL throughput: got %0d cycles, want %0d", used, N);
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (obs_mag[k] !== 2 * k) begin
        errors++;
        $display("FAIL natural_mag[%0d]: got %0d, want %0d", k, obs_mag[k], 2 * k);
      end
    end
    checks++;
    if (o_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL valid_drop: got v=%0b busy=%0b, want 0 0", o_valid, busy);
    end
  endtask

  task automatic test_backpressure();
    int used;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < N; k++) exp_frame[k] = 16'($urandom);
      start_frame32();
      drain32(1, -1, {(N*MSB){1'b0}}, used);
    end
    for (int k = 0; k < N; k++) exp_frame[k] = 16'($urandom);
    start_frame32();
    drain32(2, -1, {(N*MSB){1'b0}}, used);
  endtask

  task automatic test_mag_edge();
    int used;
    for (int k = 0; k < N; k++) exp_frame[k] = 16'($urandom);
    exp_frame[0] = 16'h8080;
    exp_frame[1] = 16'h7F80;
    exp_frame[2] = 16'h0000;
    start_frame32();
    drain32(0, -1, {(N*MSB){1'b0}}, used);
    checks++;
    if (obs_mag[0] !== 256 || obs_mag[1] !== 255 || obs_mag[2] !== 0) begin
      errors++;
      $display("FAIL mag_edge: got %0d %0d %0d, want 256 255 0", obs_mag[0], obs_mag[1], obs_mag[2]);
    end
  endtask

  task automatic test_bitrev();
    int b;
    for (int k = 0; k < N8; k++) din8[k*MSB +: MSB] = 16'(k);
    fv8 = 1'b1;
    step();
    fv8 = 1'b0;
    step();
    for (int i = 0; i < N8; i++) begin
      b = ref_rev(i, 3);
      checks++;
      if (o_valid8 !== 1'b1 || o_index8 !== 3'(b) || o_data8 !== 16'(b) ||
          o_mag8 !== 9'(ref_mag(16'(b))) || o_last8 !== (i == N8 - 1)) begin
        errors++;
        $display("FAIL bitrev[%0d]: got v=%0b i=%0d d=%h m=%0d l=%0b, want v=1 i=%0d d=%h m=%0d l=%0b",
                 i, o_valid8, o_index8, o_data8, o_mag8, o_last8, b, b, b, (i == N8 - 1));
      end
      step();
    end
    checks++;
    if (o_valid8 !== 1'b0) begin
      errors++;
      $display("FAIL bitrev_end: got v=%0b, want 0", o_valid8);
    end
  endtask

  task automatic test_back_to_back();
    int used;
    for (int k = 0; k < N; k++) exp_frame[k] = 16'($urandom);
    for (int k = 0; k < N; k++) nxt_frame[k] = 16'($urandom);
    start_frame32();
    drain32(0, N - 1, pack_frame(nxt_frame), used);
    checks++;
    if (o_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap: got v=%0b busy=%0b, want v=0 busy=1", o_valid, busy);
    end
    step();
    checks++;
    if (o_valid !== 1'b1 || o_index !== 5'd0 || o_data !== nxt_frame[0] || overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: got v=%0b i=%0d d=%h ovr=%0b, want v=1 i=0 d=%h ovr=0",
               o_valid, o_index, o_data, overrun, nxt_frame[0]);
    end
    for (int k = 0; k < N; k++) exp_frame[k] = nxt_frame[k];
    drain32(2, -1, {(N*MSB){1'b0}}, used);
  endtask

  task automatic test_overrun();
    int used;
    for (int k = 0; k < N; k++) exp_frame[k] = 16'($urandom);
    for (int k = 0; k < N; k++) nxt_frame[k] = 16'($urandom);
    start_frame32();
    drain32(0, 10, pack_frame(nxt_frame), used);
    checks++;
    if (overrun !== 1'b1 || o_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL overrun_drop: got ovr=%0b v=%0b busy=%0b, want 1 0 0", overrun, o_valid, busy);
    end
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: got %0b, want 0", overrun);
    end
    // Drop during LOAD together with a clear: the set must win.
    for (int k = 0; k < N; k++) exp_frame[k] = 16'($urandom);
    start_frame32();
    frame_valid = 1'b1;
    clr_overrun = 1'b1;
    fft_data_in = pack_frame(nxt_frame);
    step();
    frame_valid = 1'b0;
    clr_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set_wins: got %0b, want 1", overrun);
    end
    drain32(0, -1, {(N*MSB){1'b0}}, used);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear2: got %0b, want 0", overrun);
    end
  endtask

  task automatic test_reset_midstream();
    int used;
    for (int k = 0; k < N; k++) exp_frame[k] = 16'($urandom);
    start_frame32();
    step();
    o_ready = 1'b1;
    repeat (5) step();
    checks++;
    if (o_valid !== 1'b1 || o_index !== 5'd5) begin
      errors++;
      $display("FAIL pre_reset_word: got v=%0b i=%0d, want v=1 i=5", o_valid, o_index);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || busy !== 1'b0 || o_index !== 5'd0 || o_last !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got v=%0b busy=%0b i=%0d l=%0b, want 0 0 0 0",
               o_valid, busy, o_index, o_last);
    end
    #1;
    rst_n   = 1'b1;
    o_ready = 1'b0;
    step();
    for (int k = 0; k < N; k++) exp_frame[k] = 16'($urandom);
    start_frame32();
    drain32(2, -1, {(N*MSB){1'b0}}, used);
  endtask

  initial begin
    rst_n = 1'b0; frame_valid = 1'b0; fft_data_in = {(N*MSB){1'b0}};
    o_ready = 1'b0; clr_overrun = 1'b0;
    fv8 = 1'b0; din8 = {(N8*MSB){1'b0}}; rdy8 = 1'b1; clr8 = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    test_reset();
    test_natural();
    test_backpressure();
    test_mag_edge();
    test_bitrev();
    test_back_to_back();
    test_overrun();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
